// File: rtl/panda_pkg.sv
// panda_pkg: shared types for the panda execute-stage divider.
//   div_op_e    - RV32M divide/remainder operation select
//   div_state_e - divider control FSM states
// Helper functions classify an operation as signed and/or remainder-producing.
package panda_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/panda_adder.sv
// panda_adder: Width-bit adder/subtractor shared by the ALU and the divider.
//   a_i        - first operand
//   b_i        - second operand
//   subtract_i - 1: sum_o = a_i - b_i, 0: sum_o = a_i + b_i
//   sum_o      - Width-bit result (wraps modulo 2**Width)
module panda_adder #(
  parameter int Width = 33
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             subtract_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] b_eff;

  // Subtraction is a + ~b + 1: invert b per bit, feed the +1 as carry-in.
  genvar gi;
  generate
    for (gi = 0; gi < Width; gi++) begin : g_inv
      assign b_eff[gi] = b_i[gi] ^ subtract_i;
    end
  endgenerate

  assign sum_o = a_i + b_eff + {{(Width-1){1'b0}}, subtract_i};

endmodule

// File: rtl/panda_divider.sv
// panda_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk_i       - clock, rising edge
//   rst_ni      - asynchronous active-low reset
//   valid_i     - request valid; accepted when ready_o=1 and kill_i=0
//   ready_o     - divider idle and able to accept a request
//   op_i        - operation (div_op_e)
//   operand_a_i - dividend, sampled only on the accepting edge
//   operand_b_i - divisor, sampled only on the accepting edge
//   kill_i      - pipeline flush; aborts any operation in flight
//   valid_o     - result valid; held until ready_i
//   ready_i     - consumer accepts the result
//   result_o    - quotient or remainder (registered)
// One bit of quotient is produced per CALC cycle; divide-by-zero and signed
// overflow are resolved at accept time and skip CALC entirely.
module panda_divider import panda_pkg::*; #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  div_op_e          op_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o
);

  localparam int CntW = $clog2(Width);
  localparam logic [CntW-1:0]  CntLoad = CntW'(Width - 1);
  localparam logic [Width-1:0] MinVal  = {1'b1, {(Width-1){1'b0}}};

  div_state_e       state_reg, state_next;
  logic [CntW-1:0]  counter_reg;
  div_op_e          op_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [Width-1:0] q_reg;
  // Remainder is kept at Width bits: a stored trial result is always below
  // |b|, so the extra MSB of the Width+1-bit partial remainder is always zero.
  logic [Width-1:0] r_reg;
  logic [Width-1:0] b_reg;
  logic [Width-1:0] result_reg;

  // ---------------- accept-time decode ----------------
  logic             accept;
  logic             a_neg, b_neg;
  logic [Width-1:0] a_abs, b_abs;
  logic             div_zero, overflow;

  assign accept   = (state_reg == IDLE) && valid_i && !kill_i;
  assign a_neg    = op_is_signed(op_i) && operand_a_i[Width-1];
  assign b_neg    = op_is_signed(op_i) && operand_b_i[Width-1];
  assign a_abs    = a_neg ? -operand_a_i : operand_a_i;
  assign b_abs    = b_neg ? -operand_b_i : operand_b_i;
  assign div_zero = (operand_b_i == '0);
  assign overflow = op_is_signed(op_i) && (operand_a_i == MinVal) &&
                    (operand_b_i == '1);

  // ---------------- one restoring step ----------------
  logic [Width:0]   shifted;
  logic [Width:0]   trial;
  logic             take;
  logic [Width-1:0] r_step, q_step;
  logic [Width-1:0] q_fix, r_fix, final_val;

  assign shifted = {r_reg, q_reg[Width-1]};

  panda_adder #(
    .Width (Width + 1)
  ) u_trial_sub (
    .a_i        (shifted),
    .b_i        ({1'b0, b_reg}),
    .subtract_i (1'b1),
    .sum_o      (trial)
  );

  // Non-negative trial means |b| fits: keep the difference, shift in a 1.
  // When it doesn't fit, shifted < |b| < 2**Width so truncation is lossless.
  assign take   = !trial[Width];
  assign r_step = take ? trial[Width-1:0] : shifted[Width-1:0];
  assign q_step = {q_reg[Width-2:0], take};

  assign q_fix     = neg_q_reg ? -q_step : q_step;
  assign r_fix     = neg_r_reg ? -r_step : r_step;
  assign final_val = op_is_rem(op_reg) ? r_fix : q_fix;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) begin
          state_next = (div_zero || overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        if (kill_i) begin
          state_next = IDLE;
        end else if (counter_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (kill_i || ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter_reg <= '0;
      op_reg      <= DIV;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      q_reg       <= '0;
      r_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
    end else if (accept) begin
      op_reg      <= op_i;
      neg_q_reg   <= a_neg ^ b_neg;
      neg_r_reg   <= a_neg;
      q_reg       <= a_abs;
      b_reg       <= b_abs;
      r_reg       <= '0;
      counter_reg <= CntLoad;
      // Special cases use the original operands, not the magnitudes.
      if (div_zero) begin
        result_reg <= op_is_rem(op_i) ? operand_a_i : '1;
      end else if (overflow) begin
        result_reg <= op_is_rem(op_i) ? '0 : operand_a_i;
      end
    end else if ((state_reg == CALC) && !kill_i) begin
      q_reg       <= q_step;
      r_reg       <= r_step;
      counter_reg <= counter_reg - CntW'(1);
      if (counter_reg == '0) begin
        result_reg <= final_val;
      end
    end
  end

  assign result_o = result_reg;

endmodule
